// File: rtl/ftdi_pkg.sv
// Shared definitions for the FT60x burst write engine: FSM encoding, bus
// width defaults and the counter-width helper.
package ftdi_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Bits needed to index 'value' items; never less than one so that
    // single-entry cases still get a legal vector.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ftdi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer register is owned by the instantiating engine.
module ftdi_rr_arbiter
    import ftdi_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int PTR_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    // NOTE: every output gets a default before the search loops, otherwise a
    // path with no requester would hold the old value and infer a latch.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        // First pass covers ptr..N_CH-1, second pass wraps to 0..ptr-1.
        for (int j = 0; j < N_CH; j++) begin
            if (!grant_valid && req[j] && (j >= int'(ptr))) begin
                grant       = '0;
                grant[j]    = 1'b1;
                grant_idx   = PTR_W'(j);
                grant_valid = 1'b1;
            end
        end
        for (int j = 0; j < N_CH; j++) begin
            if (!grant_valid && req[j]) begin
                grant       = '0;
                grant[j]    = 1'b1;
                grant_idx   = PTR_W'(j);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ftdi_burst_writer.sv
// Multi-channel FT60x 245-synchronous write engine: round-robin bursts onto
// DATA/BE/WR_N with a single output register that holds while TXE_N is high.
module ftdi_burst_writer
    import ftdi_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BE_W      = DATA_W / 8,
    parameter int N_CH      = 2,
    parameter int BURST_MAX = 256,
    parameter int STAT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH*BE_W-1:0]   ch_be,
    input  logic [N_CH-1:0]        ch_last,
    input  logic [N_CH-1:0]        ch_valid,
    output logic [N_CH-1:0]        ch_ready,
    input  logic                   ftdi_txe_n,
    output logic [DATA_W-1:0]      ftdi_data,
    output logic [BE_W-1:0]        ftdi_be,
    output logic                   ftdi_wr_n,
    output logic                   ftdi_drive,
    output logic                   busy,
    output logic [STAT_W-1:0]      word_cnt,
    output logic [STAT_W-1:0]      burst_cnt,
    output logic [STAT_W-1:0]      stall_cnt
);

    localparam int PTR_W = clog2_min1(N_CH);
    localparam int CNT_W = clog2_min1(BURST_MAX);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_MAX - 1);
    localparam logic [PTR_W-1:0] LAST_CH   = PTR_W'(N_CH - 1);

    state_t              state_q, state_d;
    logic [N_CH-1:0]     grant_oh_q, grant_oh_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [STAT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [STAT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [STAT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [N_CH-1:0]     arb_grant;
    logic [PTR_W-1:0]    arb_idx;
    logic                arb_valid;

    logic [DATA_W-1:0]   sel_data;
    logic [BE_W-1:0]     sel_be;
    logic                sel_last;
    logic                sel_valid;
    logic                can_load;
    logic                take;
    logic                xfer;
    logic                burst_end;

    ftdi_rr_arbiter #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_arb (
        .req         (ch_valid),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        sel_data  = '0;
        sel_be    = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_oh_q[i]) begin
                sel_data  = ch_data[i*DATA_W +: DATA_W];
                sel_be    = ch_be[i*BE_W +: BE_W];
                sel_last  = ch_last[i];
                sel_valid = ch_valid[i];
            end
        end

        // The register can reload in the same cycle it empties onto the bus,
        // which is what sustains one word per clock while TXE_N stays low.
        xfer      = out_valid_q & ~ftdi_txe_n;
        can_load  = (state_q == ST_BURST) & (~out_valid_q | ~ftdi_txe_n);
        ch_ready  = grant_oh_q & {N_CH{can_load}};
        take      = can_load & sel_valid;
        burst_end = take & (sel_last | (words_q == LAST_WORD));

        state_d     = state_q;
        grant_oh_d  = grant_oh_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        words_d     = words_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        be_d        = be_q;
        burst_cnt_d = burst_cnt_q;
        word_cnt_d  = word_cnt_q + STAT_W'(xfer);
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && ftdi_txe_n && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        if (take) begin
            out_valid_d = 1'b1;
            data_d      = sel_data;
            be_d        = sel_be;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && arb_valid) begin
                    grant_oh_d = arb_grant;
                    grant_d    = arb_idx;
                    words_d    = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (take) words_d = words_q + 1'b1;
                // A dropped enable still lets a word taken this cycle complete.
                if (burst_end || !enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!out_valid_q || xfer) state_d = ST_GAP;
            end
            ST_GAP: begin
                burst_cnt_d = burst_cnt_q + 1'b1;
                rr_ptr_d    = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_oh_q  <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            words_q     <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            be_q        <= '0;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_oh_q  <= grant_oh_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            words_q     <= words_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            be_q        <= be_d;
            word_cnt_q  <= word_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ftdi_data  = data_q;
    assign ftdi_be    = be_q;
    assign ftdi_wr_n  = ~out_valid_q;
    assign ftdi_drive = (state_q != ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign word_cnt   = word_cnt_q;
    assign burst_cnt  = burst_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ftdi_burst_writer.sv
// Scoreboard bench for ftdi_burst_writer: instance A uses a long burst limit,
// instance B a 4-word limit; only the selected instance is ever enabled.
module tb_ftdi_burst_writer;

    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int NC   = 2;
    localparam int SW   = 32;
    localparam int TR_N = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic sel = 1'b0;
    logic txe_n = 1'b0;
    logic [NC*DW-1:0] ch_data = '0;
    logic [NC*BW-1:0] ch_be = '0;
    logic [NC-1:0]    ch_last = '0;
    logic [NC-1:0]    ch_valid = '0;

    logic [NC-1:0] a_ready, b_ready, m_ready;
    logic [DW-1:0] a_data, b_data, m_data;
    logic [BW-1:0] a_be, b_be, m_be;
    logic          a_wr_n, b_wr_n, m_wr_n;
    logic          a_drive, b_drive, m_drive;
    logic          a_busy, b_busy, m_busy;
    logic [SW-1:0] a_word, b_word, m_word;
    logic [SW-1:0] a_burst, b_burst, m_burst;
    logic [SW-1:0] a_stall, b_stall, m_stall;

    ftdi_burst_writer #(.DATA_W(DW), .N_CH(NC), .BURST_MAX(256), .STAT_W(SW)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a),
        .ch_data(ch_data), .ch_be(ch_be), .ch_last(ch_last), .ch_valid(ch_valid),
        .ch_ready(a_ready), .ftdi_txe_n(txe_n),
        .ftdi_data(a_data), .ftdi_be(a_be), .ftdi_wr_n(a_wr_n), .ftdi_drive(a_drive),
        .busy(a_busy), .word_cnt(a_word), .burst_cnt(a_burst), .stall_cnt(a_stall)
    );

    ftdi_burst_writer #(.DATA_W(DW), .N_CH(NC), .BURST_MAX(4), .STAT_W(SW)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b),
        .ch_data(ch_data), .ch_be(ch_be), .ch_last(ch_last), .ch_valid(ch_valid),
        .ch_ready(b_ready), .ftdi_txe_n(txe_n),
        .ftdi_data(b_data), .ftdi_be(b_be), .ftdi_wr_n(b_wr_n), .ftdi_drive(b_drive),
        .busy(b_busy), .word_cnt(b_word), .burst_cnt(b_burst), .stall_cnt(b_stall)
    );

    assign m_ready = sel ? b_ready : a_ready;
    assign m_data  = sel ? b_data  : a_data;
    assign m_be    = sel ? b_be    : a_be;
    assign m_wr_n  = sel ? b_wr_n  : a_wr_n;
    assign m_drive = sel ? b_drive : a_drive;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_word  = sel ? b_word  : a_word;
    assign m_burst = sel ? b_burst : a_burst;
    assign m_stall = sel ? b_stall : a_stall;

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int src_n[NC];
    int src_end[NC];
    bit src_en[NC];
    exp_t sb0[$];
    exp_t sb1[$];
    int ch_log[$];

    logic          wr_tr[TR_N];
    logic          drv_tr[TR_N];
    logic          take_tr[TR_N];
    logic [DW-1:0] dat_tr[TR_N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int c, input int n);
        return DW'((c << 16) | n);
    endfunction

    function automatic logic [BW-1:0] be_of(input int c);
        return (c == 0) ? 4'hF : 4'h3;
    endfunction

    task automatic drive_src();
        for (int c = 0; c < NC; c++) begin
            ch_data[c*DW +: DW] = word_of(c, src_n[c]);
            ch_be[c*BW +: BW]   = be_of(c);
            ch_last[c]          = (src_n[c] == src_end[c]);
            ch_valid[c]         = src_en[c] && (src_n[c] <= src_end[c]);
        end
    endtask

    // One clock: present sources, sample at negedge, push accepted words.
    task automatic step();
        logic [NC-1:0] took;
        exp_t e;
        drive_src();
        @(negedge clk);
        took = ch_valid & m_ready;
        if (cyc < TR_N) begin
            wr_tr[cyc]   = m_wr_n;
            drv_tr[cyc]  = m_drive;
            take_tr[cyc] = |took;
            dat_tr[cyc]  = m_data;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            if (took[c]) begin
                e.data = word_of(c, src_n[c]);
                e.be   = be_of(c);
                if (c == 0) sb0.push_back(e);
                else        sb1.push_back(e);
                src_n[c]++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        txe_n = 1'b0;
        for (int c = 0; c < NC; c++) begin
            src_n[c]   = 1;
            src_end[c] = 0;
            src_en[c]  = 1'b0;
        end
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        sb0.delete();
        sb1.delete();
        ch_log.delete();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int ch;
        if (!rst && m_wr_n == 1'b0 && txe_n == 1'b0) begin
            ch = int'(m_data[16]);
            ch_log.push_back(ch);
            if (ch == 0) begin
                check("sb_ch0_pending", 64'(sb0.size() != 0), 1);
                if (sb0.size() != 0) begin
                    e = sb0.pop_front();
                    check("xfer_ch0", {m_data, m_be}, e);
                end
            end else begin
                check("sb_ch1_pending", 64'(sb1.size() != 0), 1);
                if (sb1.size() != 0) begin
                    e = sb1.pop_front();
                    check("xfer_ch1", {m_data, m_be}, e);
                end
            end
        end
    end

    initial begin
        int first;
        int run;
        int cnt;
        int runs[$];
        int exp_ch[12];
        logic prev;

        // Reset state
        do_reset();
        check("rst_wr_n", a_wr_n, 1);
        check("rst_drive", a_drive, 0);
        check("rst_data", a_data, 0);
        check("rst_be", a_be, 0);
        check("rst_ready", a_ready, 0);
        check("rst_busy", a_busy, 0);
        check("rst_counters", {a_word, a_burst}, 0);
        check("rst_stall", a_stall, 0);
        check("rst_b_wr_n", b_wr_n, 1);

        // Single 10-word packet on ch0, TXE always low
        sel = 1'b0; en_a = 1'b1;
        src_end[0] = 10; src_en[0] = 1'b1;
        repeat (20) step();
        first = -1;
        for (int i = 0; i < 20; i++) if (take_tr[i] && first < 0) first = i;
        check("t1_first_take", first, 1);
        if (first < 0) first = 0;
        run = 0;
        for (int i = first + 1; i < 20; i++) begin
            if (wr_tr[i] == 1'b0 && run == i - first - 1) run++;
        end
        check("t1_wr_low_run", run, 10);
        check("t1_gap_wr_n", wr_tr[first + 11], 1);
        check("t1_gap_drive", drv_tr[first + 11], 1);
        check("t1_idle_drive", drv_tr[first + 12], 0);
        check("t1_burst_cnt", a_burst, 1);
        check("t1_word_cnt", a_word, 10);
        check("t1_sb_drained", 64'(sb0.size()), 0);

        // BURST_MAX=4, both channels streaming; ch1's last lands on word 4
        do_reset();
        sel = 1'b1; en_b = 1'b1;
        src_end[0] = 8; src_en[0] = 1'b1;
        src_end[1] = 4; src_en[1] = 1'b1;
        repeat (30) step();
        runs.delete();
        prev = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (!wr_tr[i] && prev) runs.push_back(1);
            else if (!wr_tr[i]) runs[runs.size() - 1]++;
            prev = wr_tr[i];
        end
        check("t2_burst_runs", 64'(runs.size()), 3);
        for (int i = 0; i < runs.size(); i++) check("t2_run_len", runs[i], 4);
        exp_ch = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        check("t2_log_len", 64'(ch_log.size()), 12);
        for (int i = 0; i < 12 && i < ch_log.size(); i++) check("t2_channel_order", ch_log[i], exp_ch[i]);
        check("t2_burst_cnt", b_burst, 3);
        check("t2_word_cnt", b_word, 12);
        check("t2_sb_drained", 64'(sb0.size() + sb1.size()), 0);

        // TXE high for three cycles while word 5 sits on the bus
        do_reset();
        sel = 1'b0; en_a = 1'b1;
        src_end[0] = 10; src_en[0] = 1'b1;
        repeat (20) begin
            txe_n = (cyc >= 6 && cyc <= 8);
            step();
        end
        for (int i = 6; i <= 8; i++) check("t3_hold_data", {wr_tr[i], dat_tr[i]}, {1'b0, 32'h0000_0005});
        check("t3_next_word", dat_tr[10], 32'h0000_0006);
        check("t3_stall_cnt", a_stall, 3);
        check("t3_word_cnt", a_word, 10);
        check("t3_sb_drained", 64'(sb0.size()), 0);

        // Granted channel goes invalid for two cycles mid-burst
        do_reset();
        sel = 1'b0; en_a = 1'b1;
        src_end[0] = 8;
        repeat (20) begin
            src_en[0] = !(cyc == 4 || cyc == 5);
            step();
            if (cyc == 8) check("t4_burst_mid", a_burst, 0);
        end
        check("t4_wr_pattern", {wr_tr[4], wr_tr[5], wr_tr[6], wr_tr[7]}, 4'b0110);
        check("t4_drive_held", {drv_tr[5], drv_tr[6]}, 2'b11);
        check("t4_burst_cnt", a_burst, 1);
        check("t4_word_cnt", a_word, 8);
        check("t4_sb_drained", 64'(sb0.size()), 0);

        // Enable drops while word 3 of a 20-word packet is taken
        do_reset();
        sel = 1'b0;
        src_end[0] = 20; src_en[0] = 1'b1;
        repeat (30) begin
            en_a = (cyc < 3);
            step();
        end
        cnt = 0;
        for (int i = 6; i < 30; i++) if (drv_tr[i]) cnt++;
        check("t5_no_new_burst", cnt, 0);
        check("t5_word_cnt", a_word, 3);
        check("t5_burst_cnt", a_burst, 1);
        check("t5_busy", a_busy, 0);
        check("t5_sb_drained", 64'(sb0.size()), 0);

        // Asynchronous reset in the middle of a ch1 burst
        do_reset();
        sel = 1'b0; en_a = 1'b1;
        src_end[0] = 2;  src_en[0] = 1'b1;
        src_end[1] = 20; src_en[1] = 1'b1;
        repeat (8) step();
        check("t6_pre_log_len", 64'(ch_log.size()), 3);
        if (ch_log.size() >= 3) check("t6_pre_ch1_granted", ch_log[2], 1);
        check("t6_pre_word_cnt", a_word, 3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_wr_n", a_wr_n, 1);
        check("t6_rst_drive", a_drive, 0);
        check("t6_rst_counters", {a_word, a_burst, a_stall}, 0);
        check("t6_rst_busy", a_busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb0.delete();
        sb1.delete();
        ch_log.delete();
        src_n[0] = 1; src_end[0] = 3;
        cyc = 0;
        repeat (10) step();
        check("t6_post_log_len", 64'(ch_log.size() >= 4), 1);
        if (ch_log.size() >= 4) begin
            check("t6_post_first_ch0", {ch_log[0][3:0], ch_log[1][3:0], ch_log[2][3:0]}, 0);
            check("t6_post_then_ch1", ch_log[3], 1);
        end
        check("t6_post_burst_cnt", a_burst, 1);
        check("t6_post_word_cnt", a_word, 5);
        en_a = 1'b0;
        src_en[0] = 1'b0; src_en[1] = 1'b0;
        repeat (8) step();
        check("t6_unused_mux", {m_busy, m_word[0], m_burst[0], m_stall[0], m_drive}, {1'b0, m_word[0], m_burst[0], m_stall[0], 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
